alu_mdu_seq: RTL and testbench

//  Parametrised successor to the single-cycle RV32I ALU: registered base ALU plus iterative
//  RV32M multiply/divide unit behind a valid/ready handshake on input and output.

---
 rtl/alu_mdu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// Registered RV32I base ALU plus iterative RV32M multiply/divide behind valid/ready handshakes.
// Define ALU_DIV_EN to build the iterative divider; otherwise DIV-class ops return 0 in one cycle.
module alu_mdu_seq #(
    parameter int unsigned DATAW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [DATAW-1:0] A,
    input  logic [DATAW-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] result,
    output logic             busy
);
    localparam int unsigned SHAMTW = $clog2(DATAW);
    localparam int unsigned CNTW   = SHAMTW;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSlt  = 4'd2;
    localparam logic [3:0] AluSltu = 4'd3;
    localparam logic [3:0] AluAnd  = 4'd4;
    localparam logic [3:0] AluOr   = 4'd5;
    localparam logic [3:0] AluXor  = 4'd6;
    localparam logic [3:0] AluSsl  = 4'd7;
    localparam logic [3:0] AluSsr  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;
    localparam logic [3:0] AluCpy  = 4'd10;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q;
    logic              out_valid_q;
    logic [DATAW-1:0]  result_q;
    logic [CNTW-1:0]   cnt_q;
    // MUL: {acc_q, lo_q} is the product/multiplier shift pair, opnd_q the multiplicand.
    // DIV: acc_q is the partial remainder, lo_q dividend/quotient, opnd_q the divisor.
    logic [DATAW-1:0]  acc_q;
    logic [DATAW-1:0]  lo_q;
    logic [DATAW-1:0]  opnd_q;
    logic [1:0]        mop_q;
    logic              neg_q;
`ifdef ALU_DIV_EN
    logic              rneg_q;
    logic              dz_q;
`endif

    logic              accept;
    logic [SHAMTW-1:0] shamt;
    logic [DATAW-1:0]  base_res;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [DATAW-1:0]  a_mag, b_mag;
    logic [DATAW:0]    mul_sum;
    logic [2*DATAW-1:0] mul_prod_d, mul_fix;

    assign in_ready  = !reset && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q == StMul) || (state_q == StDiv);
    assign shamt     = B[SHAMTW-1:0];

    always_comb begin
        base_res = '0;
        case (op[3:0])
            AluAdd:  base_res = A + B;
            AluSub:  base_res = A - B;
            AluSlt:  base_res = {{(DATAW-1){1'b0}}, $signed(A) < $signed(B)};
            AluSltu: base_res = {{(DATAW-1){1'b0}}, A < B};
            AluAnd:  base_res = A & B;
            AluOr:   base_res = A | B;
            AluXor:  base_res = A ^ B;
            AluSsl:  base_res = A << shamt;
            AluSsr:  base_res = A >> shamt;
            AluSra:  base_res = $signed(A) >>> shamt;
            AluCpy:  base_res = B;
            default: base_res = '0;
        endcase
    end

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op[2:0])
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed && A[DATAW-1];
    assign b_neg = b_signed && B[DATAW-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
    assign mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(DATAW+1){1'b0}});
    assign mul_prod_d = {mul_sum, lo_q[DATAW-1:1]};
    assign mul_fix    = neg_q ? -mul_prod_d : mul_prod_d;

`ifdef ALU_DIV_EN
    logic [DATAW:0]   div_sh;
    logic             div_ge;
    logic [DATAW-1:0] div_rem_d, div_quo_d, div_q_fix, div_r_fix;

    // Restoring step. The most-negative / -1 overflow falls out of the magnitude arithmetic.
    assign div_sh    = {acc_q, lo_q[DATAW-1]};
    assign div_ge    = div_sh >= {1'b0, opnd_q};
    assign div_rem_d = div_ge ? div_sh[DATAW-1:0] - opnd_q : div_sh[DATAW-1:0];
    assign div_quo_d = {lo_q[DATAW-2:0], div_ge};
    assign div_q_fix = dz_q ? '1 : (neg_q ? -div_quo_d : div_quo_d);
    assign div_r_fix = rneg_q ? -div_rem_d : div_rem_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            mop_q       <= '0;
            neg_q       <= 1'b0;
`ifdef ALU_DIV_EN
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!op[4]) begin
                            result_q    <= base_res;
                            out_valid_q <= 1'b1;
                        end else if (!op[2]) begin
                            state_q     <= StMul;
                            out_valid_q <= 1'b0;
                            cnt_q       <= CNTW'(DATAW - 1);
                            acc_q       <= '0;
                            lo_q        <= b_mag;
                            opnd_q      <= a_mag;
                            mop_q       <= op[1:0];
                            neg_q       <= a_neg ^ b_neg;
                        end else begin
`ifdef ALU_DIV_EN
                            state_q     <= StDiv;
                            out_valid_q <= 1'b0;
                            cnt_q       <= CNTW'(DATAW - 1);
                            acc_q       <= '0;
                            lo_q        <= a_mag;
                            opnd_q      <= b_mag;
                            mop_q       <= op[1:0];
                            neg_q       <= a_neg ^ b_neg;
                            rneg_q      <= a_neg;
                            dz_q        <= (B == '0);
`else
                            result_q    <= '0;
                            out_valid_q <= 1'b1;
`endif
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StMul: begin
                    acc_q <= mul_prod_d[2*DATAW-1:DATAW];
                    lo_q  <= mul_prod_d[DATAW-1:0];
                    if (cnt_q == '0) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        result_q    <= (mop_q == 2'b00) ? mul_fix[DATAW-1:0]
                                                        : mul_fix[2*DATAW-1:DATAW];
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                StDiv: begin
`ifdef ALU_DIV_EN
                    acc_q <= div_rem_d;
                    lo_q  <= div_quo_d;
                    if (cnt_q == '0) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        result_q    <= mop_q[1] ? div_r_fix : div_q_fix;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq: directed vector table, handshake/reset sequences and
// randomized ops checked against a plain-arithmetic reference model.
module tb_alu_mdu_seq;
`ifdef ALU_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    localparam logic [4:0] OpAdd = 5'h00, OpSub = 5'h01, OpSlt = 5'h02, OpSltu = 5'h03;
    localparam logic [4:0] OpAnd = 5'h04, OpOr = 5'h05, OpXor = 5'h06, OpSsl = 5'h07;
    localparam logic [4:0] OpSsr = 5'h08, OpSra = 5'h09, OpCpy = 5'h0A, OpBad = 5'h0F;
    localparam logic [4:0] OpMul = 5'h10, OpMulh = 5'h11, OpMulhsu = 5'h12, OpMulhu = 5'h13;
    localparam logic [4:0] OpDiv = 5'h14, OpDivu = 5'h15, OpRem = 5'h16, OpRemu = 5'h17;

    logic        clock, reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  op;
    logic [31:0] A, B, result;

    int n_vec = 0;
    int n_bad = 0;

    alu_mdu_seq #(.DATAW(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        vec_t v;
        v.name = name;
        v.op   = o;
        v.a    = a;
        v.b    = b;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    function automatic bit is_div(input logic [4:0] o);
        return o[4] && o[2];
    endfunction

    function automatic int exp_lat(input logic [4:0] o);
        if (!o[4]) return 1;
        if (is_div(o) && !DivEn) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic [31:0] ones;
        int unsigned s;
        ones = 32'hFFFF_FFFF;
        s  = int'(b[4:0]);
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (!o[4]) begin
            case (o[3:0])
                4'd0:  return a + b;
                4'd1:  return a - b;
                4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd3:  return (a < b) ? 32'd1 : 32'd0;
                4'd4:  return a & b;
                4'd5:  return a | b;
                4'd6:  return a ^ b;
                4'd7:  return a << s;
                4'd8:  return a >> s;
                4'd9:  return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
                4'd10: return b;
                default: return 32'h0;
            endcase
        end
        if (is_div(o) && !DivEn) return 32'h0;
        case (o[2:0])
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: ;
        endcase
        if (b == 32'h0) return (o[1] ? a : ones);
        if (!o[0] && a == 32'h8000_0000 && b == ones) return (o[1] ? 32'h0 : a);
        case (o[2:0])
            3'd4:    return $signed(a) / $signed(b);
            3'd5:    return a / b;
            3'd6:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Issues one op and waits for its result; latency counts the accept edge as 1.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n);
        int g;
        op = o;
        A = a;
        B = b;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
        res = result;
    endtask

    task automatic run_check(input string name, input logic [4:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int lat, bn;
        issue(o, a, b, res, lat, bn);
        check({name, ".result"}, res, exp);
        check({name, ".latency"}, 32'(lat), 32'(exp_lat(o)));
        if (exp_lat(o) > 1) check({name, ".busy_cycles"}, 32'(bn), 32'd32);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb, rexp;
        logic [4:0]  ro;
        int stale;

        add("add",      OpAdd,    32'd9,         32'd4,         32'd13);
        add("sub",      OpSub,    -32'sd78,      -32'sd901,     32'd823);
        add("sra",      OpSra,    -32'sd9,       32'd3,         32'hFFFF_FFFE);
        add("ssr",      OpSsr,    -32'sd9,       32'd3,         32'h1FFF_FFFE);
        add("sltu",     OpSltu,   -32'sd2,       32'd9,         32'd0);
        add("slt",      OpSlt,    -32'sd2,       32'd9,         32'd1);
        add("ssl_wrap", OpSsl,    32'd1,         32'd35,        32'd8);
        add("cpy",      OpCpy,    32'd5,         32'h0000_ABCD, 32'h0000_ABCD);
        add("undef",    OpBad,    32'd5,         32'd6,         32'd0);
        add("mulh_min", OpMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        add("mulhsu",   OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add("mulhu",    OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add("mul_neg",  OpMul,    32'd7,         -32'sd3,       -32'sd21);
        add("div",      OpDiv,    -32'sd7,       32'd2,         -32'sd3);
        add("rem",      OpRem,    -32'sd7,       32'd2,         -32'sd1);
        add("divu_z",   OpDivu,   32'd7,         32'd0,         32'hFFFF_FFFF);
        add("remu_z",   OpRemu,   32'd7,         32'd0,         32'd7);
        add("rem_z",    OpRem,    -32'sd5,       32'd0,         -32'sd5);
        add("div_ovf",  OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        add("rem_ovf",  OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        add("divu_72",  OpDivu,   32'd7,         32'd2,         32'd3);

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        A = '0;
        B = '0;
        #1;
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.in_ready", {31'b0, in_ready}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            rexp = vecs[i].exp;
            if (is_div(vecs[i].op) && !DivEn) rexp = 32'h0;
            run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, rexp);
        end
        repeat (2) tick();

        // Back-to-back base ops at full throughput.
        op = OpAdd; A = 32'd9; B = 32'd4; in_valid = 1'b1;
        check("b2b.ready0", {31'b0, in_ready}, 32'd1);
        tick();
        check("b2b.res0", result, 32'd13);
        check("b2b.valid0", {31'b0, out_valid}, 32'd1);
        check("b2b.ready1", {31'b0, in_ready}, 32'd1);
        op = OpSub; A = -32'sd78; B = -32'sd901;
        tick();
        in_valid = 1'b0;
        check("b2b.res1", result, 32'd823);
        check("b2b.valid1", {31'b0, out_valid}, 32'd1);
        tick();

        // Output hold under backpressure; a pending op is ignored until in_ready.
        out_ready = 1'b0;
        op = OpAdd; A = 32'd1; B = 32'd2; in_valid = 1'b1;
        tick();
        op = OpXor; A = 32'h0000_00F0; B = 32'h0000_00FF;
        for (int k = 0; k < 5; k++) begin
            check("hold.result", result, 32'd3);
            check("hold.valid", {31'b0, out_valid}, 32'd1);
            check("hold.in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("hold.release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("hold.next_result", result, 32'h0000_000F);
        check("hold.next_valid", {31'b0, out_valid}, 32'd1);
        repeat (2) tick();

        // Reset in the middle of a multiply.
        op = OpMul; A = 32'd123; B = 32'd456; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("abort.busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort.out_valid", {31'b0, out_valid}, 32'd0);
        check("abort.busy", {31'b0, busy}, 32'd0);
        check("abort.result", result, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid || busy) stale++;
            tick();
        end
        check("abort.stale_cycles", 32'(stale), 32'd0);
        run_check("post_abort_add", OpAdd, 32'd100, 32'd23, 32'd123);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 1) == 0) ro = {1'b0, 4'($urandom_range(0, 15))};
            else ro = {2'b10, 3'($urandom_range(0, 7))};
            ra = rnd_operand();
            rb = rnd_operand();
            run_check($sformatf("rnd%0d_op%02h", k, ro), ro, ra, rb, ref_res(ro, ra, rb));
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
